// File: rtl/led_pwm_driver_pkg.sv
// Shared constants and helpers for the LED PWM driver.
// Defaults match a 10-LED board with 8-bit brightness.
package led_drv_pkg;

  localparam int LED_N        = 10;
  localparam int LED_PWM_BITS = 8;

  // Clock cycles per PWM tick for a wanted frame rate, rounded to nearest,
  // never below 1 so the prescaler always has a legal terminal count.
  function automatic int calc_prescale(
    input longint clk_hz,
    input int     frame_hz,
    input int     pwm_bits
  );
    longint div;
    longint p;
    div = longint'(frame_hz) << pwm_bits;
    if (div <= 0) begin
      return 1;
    end
    p = (clk_hz + div / 2) / div;
    return (p < 1) ? 1 : int'(p);
  endfunction

endpackage

// File: rtl/led_pwm_driver_if.sv
// LED driver bus: PIO-side inputs and the LED-side outputs.
// master = PIO/software side, slave = the driver.
interface led_pwm_driver_if
  import led_drv_pkg::*;
#(
  parameter int N_LEDS   = LED_N,
  parameter int PWM_BITS = LED_PWM_BITS
);

  logic [N_LEDS-1:0]   led_pattern;
  logic [PWM_BITS-1:0] brightness;
  logic [N_LEDS-1:0]   blink_mask;
  logic [N_LEDS-1:0]   led_out;
  logic                frame_tick;

  modport master (
    output led_pattern,
    output brightness,
    output blink_mask,
    input  led_out,
    input  frame_tick
  );

  modport slave (
    input  led_pattern,
    input  brightness,
    input  blink_mask,
    output led_out,
    output frame_tick
  );

endinterface

// File: rtl/led_tick_gen.sv
// PWM tick prescaler: one-cycle tick every PRESCALE clocks.
// PRESCALE=1 keeps the counter at 0 and ticks every cycle.
module led_tick_gen #(
  parameter int PRESCALE = 196
)(
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] pre_cnt_q;
  logic [CW-1:0] pre_cnt_d;

  assign tick_o = (pre_cnt_q == LAST);

  // Next count: wrap to zero on the terminal count.
  always_comb begin
    pre_cnt_d = pre_cnt_q + CW'(1);
    if (tick_o) begin
      pre_cnt_d = '0;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/led_pwm_driver.sv
// LED driver: global PWM brightness plus per-LED blink.
// Inputs are shadowed at frame boundaries so a frame never glitches.
module led_pwm_driver
  import led_drv_pkg::*;
#(
  parameter int N_LEDS       = LED_N,
  parameter int PWM_BITS     = LED_PWM_BITS,
  parameter int PRESCALE     = 196,
  parameter int BLINK_FRAMES = 250
)(
  input logic              clk,
  input logic              reset,
  led_pwm_driver_if.slave  bus
);

  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

  logic                tick;
  logic                wrap;
  logic                pwm_on;

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [FW-1:0]       frm_cnt_q, frm_cnt_d;
  logic                phase_q, phase_d;
  logic [N_LEDS-1:0]   pat_sh_q, pat_sh_d;
  logic [PWM_BITS-1:0] bri_sh_q, bri_sh_d;
  logic [N_LEDS-1:0]   blk_sh_q, blk_sh_d;
  logic [N_LEDS-1:0]   led_out_q, led_out_d;
  logic                frame_tick_q, frame_tick_d;

  led_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  assign wrap = tick && (pwm_cnt_q == PWM_MAX);

  // Counters, blink phase and input shadows; all frame-scoped state
  // changes together on the wrap edge.
  always_comb begin
    pwm_cnt_d    = pwm_cnt_q;
    frm_cnt_d    = frm_cnt_q;
    phase_d      = phase_q;
    pat_sh_d     = pat_sh_q;
    bri_sh_d     = bri_sh_q;
    blk_sh_d     = blk_sh_q;
    frame_tick_d = wrap;
    if (tick) begin
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    end
    if (wrap) begin
      pat_sh_d = bus.led_pattern;
      bri_sh_d = bus.brightness;
      blk_sh_d = bus.blink_mask;
      if (frm_cnt_q == FRM_LAST) begin
        frm_cnt_d = '0;
        phase_d   = ~phase_q;
      end else begin
        frm_cnt_d = frm_cnt_q + FW'(1);
      end
    end
  end

  // Duty compare and LED drive; full scale forces steady on.
  always_comb begin
    pwm_on    = (bri_sh_q == PWM_MAX) | (pwm_cnt_q < bri_sh_q);
    led_out_d = pat_sh_q
              & {N_LEDS{pwm_on}}
              & (~blk_sh_q | {N_LEDS{phase_q}});
  end

  // State and output registers; reset darkens LEDs immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_q    <= '0;
      frm_cnt_q    <= '0;
      phase_q      <= 1'b0;
      pat_sh_q     <= '0;
      bri_sh_q     <= '0;
      blk_sh_q     <= '0;
      led_out_q    <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      pwm_cnt_q    <= pwm_cnt_d;
      frm_cnt_q    <= frm_cnt_d;
      phase_q      <= phase_d;
      pat_sh_q     <= pat_sh_d;
      bri_sh_q     <= bri_sh_d;
      blk_sh_q     <= blk_sh_d;
      led_out_q    <= led_out_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.led_out    = led_out_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver: frame-arithmetic reference model,
// per-cycle compare, directed literal checks and random stimulus.
module tb_led_pwm_driver;

  localparam int N  = 10;
  localparam int PB = 3;
  localparam int PS = 2;
  localparam int BF = 2;
  localparam int F  = PS * (1 << PB);
  localparam int BMAX = (1 << PB) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  bit   run_cmp = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_pwm_driver_if #(.N_LEDS(N), .PWM_BITS(PB)) bus ();

  led_pwm_driver #(
    .N_LEDS       (N),
    .PWM_BITS     (PB),
    .PRESCALE     (PS),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // Reference: t = clocks since reset release. Frame f = t/F, PWM level
  // = position in frame / PS, blink phase = (f/BF) odd.
  int              t;
  logic [N-1:0]    sh_pat, sh_blk, exp_led;
  logic [PB-1:0]   sh_bri;
  logic            exp_ft;

  function automatic logic [N-1:0] model_led(input int tt,
      input logic [N-1:0] pat, input logic [PB-1:0] bri,
      input logic [N-1:0] blk);
    int  lvl;
    int  f;
    bit  on;
    bit  ph;
    lvl = (tt % F) / PS;
    f   = tt / F;
    ph  = ((f / BF) % 2) == 1;
    on  = (int'(bri) == BMAX) || (lvl < int'(bri));
    if (!on) return '0;
    return ph ? pat : (pat & ~blk);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t       <= 0;
      sh_pat  <= '0;
      sh_bri  <= '0;
      sh_blk  <= '0;
      exp_led <= '0;
      exp_ft  <= 1'b0;
    end else begin
      exp_led <= model_led(t, sh_pat, sh_bri, sh_blk);
      exp_ft  <= ((t % F) == F - 1);
      if ((t % F) == F - 1) begin
        sh_pat <= bus.led_pattern;
        sh_bri <= bus.brightness;
        sh_blk <= bus.blink_mask;
      end
      t <= t + 1;
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      check("led_out", 32'(bus.led_out), 32'(exp_led));
      check("frame_tick", 32'(bus.frame_tick), 32'(exp_ft));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic [N-1:0] p, input logic [PB-1:0] b,
                        input logic [N-1:0] m);
    bus.led_pattern = p;
    bus.brightness  = b;
    bus.blink_mask  = m;
  endtask

  task automatic wait_to(input int target);
    int guard;
    guard = 0;
    while (t < target && guard < 1000) begin
      step();
      guard++;
    end
    if (t != target) check("wait_to", 32'(t), 32'(target));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    int cnt;
    int bad;
    int last;
    logic [N-1:0] acc;
    logic [80:0]  b0;
    int n_ft;
    int rst_at;

    set_in(10'h3FF, 3'd7, '0);
    #1 reset = 1'b1;
    run_cmp = 1'b1;
    step();
    step();
    reset = 1'b0;

    // 1: async reset while fully lit, then dark until first load
    wait_to(32);
    check("lit_before_reset", 32'(bus.led_out), 32'h3FF);
    #1 reset = 1'b1;
    #1;
    check("async_led_clear", 32'(bus.led_out), 32'h0);
    check("async_ft_clear", 32'(bus.frame_tick), 32'h0);
    set_in(10'h155, 3'd4, '0);
    @(posedge clk);
    #2 reset = 1'b0;
    first = -1;
    acc = '0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus.frame_tick && first < 0) first = k;
      if (k <= 16) acc |= bus.led_out;
    end
    check("first_tick_clk", 32'(first), 32'd16);
    check("dark_until_load", 32'(acc), 32'h0);

    // 2: brightness 4/8 on even bits
    wait_to(32);
    cnt = 0;
    acc = '0;
    for (int k = 0; k < F; k++) begin
      step();
      if (bus.led_out[0]) cnt++;
      acc |= bus.led_out & 10'h2AA;
    end
    check("half_duty_count", 32'(cnt), 32'd8);
    check("odd_bits_dark", 32'(acc), 32'h0);

    // 3: full scale never dips; zero stays dark
    set_in(10'h155, 3'd7, '0);
    wait_to(64);
    bad = 0;
    for (int k = 0; k < 2 * F; k++) begin
      step();
      if (bus.led_out != 10'h155) bad++;
    end
    check("full_scale_dips", 32'(bad), 32'd0);
    set_in(10'h155, 3'd0, '0);
    wait_to(112);
    acc = '0;
    for (int k = 0; k < F; k++) begin
      step();
      acc |= bus.led_out;
    end
    check("zero_bri_dark", 32'(acc), 32'h0);

    // 4: mid-frame change held until next boundary
    set_in(10'h001, 3'd7, '0);
    wait_to(149);
    set_in(10'h200, 3'd7, '0);
    bad = 0;
    while (t < 159) begin
      step();
      if (bus.led_out != 10'h001 || bus.frame_tick) bad++;
    end
    check("hold_old_pattern", 32'(bad), 32'd0);
    step();
    check("tick_at_boundary", 32'(bus.frame_tick), 32'd1);
    check("old_at_tick", 32'(bus.led_out), 32'h001);
    step();
    check("new_after_tick", 32'(bus.led_out), 32'h200);

    // random stimulus with one reset at a random point
    rst_at = $urandom_range(20, 100);
    for (int k = 0; k < 8 * F; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: bus.brightness = '0;
          1: bus.brightness = 3'd7;
          default: bus.brightness = PB'($urandom);
        endcase
        bus.led_pattern = N'($urandom);
        bus.blink_mask  = N'($urandom);
      end
      if (k == rst_at) begin
        #1 reset = 1'b1;
        #1;
        check("rand_async_clear", 32'(bus.led_out), 32'h0);
        step();
        reset = 1'b0;
      end
      step();
    end

    // 5: blink 2 frames dark / 2 lit
    set_in(10'h003, 3'd7, 10'h001);
    do_reset();
    b0 = '0;
    cnt = 0;
    for (int k = 1; k <= 80; k++) begin
      step();
      b0[k] = bus.led_out[0];
      if (k >= 17 && bus.led_out[1]) cnt++;
    end
    check("steady_bit1", 32'(cnt), 32'd64);
    cnt = 0;
    for (int k = 17; k <= 80; k++) if (b0[k]) cnt++;
    check("blink_lit_count", 32'(cnt), 32'd32);
    check("blink_dark_f1", 32'(b0[24]), 32'd0);
    check("blink_lit_f2", 32'(b0[40]), 32'd1);
    check("blink_lit_f3", 32'(b0[56]), 32'd1);
    check("blink_dark_f4", 32'(b0[72]), 32'd0);

    // 6: frame_tick cadence over 160 clocks
    n_ft = 0;
    last = -1;
    bad = 0;
    for (int k = 0; k < 160; k++) begin
      step();
      if (bus.frame_tick) begin
        if (last >= 0 && (k - last) != F) bad++;
        last = k;
        n_ft++;
      end
    end
    check("tick_count", 32'(n_ft), 32'd10);
    check("tick_spacing", 32'(bad), 32'd0);

    @(posedge clk);
    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
